regfile_autoclear: RTL and testbench
====================================

REGFILE_AUTOCLEAR -- requirements
Module: regfile_autoclear

Interface
REQ-001 The block SHALL expose these parameters:
- WIDTH, 32, data word width in bits.
- ADDR_BITS, 5, register address width; NUM_REGS = 2**ADDR_BITS.

REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- Clk  input  1  clock; positive-edge triggered.
- Reset  input  1  asynchronous active-high reset.
- ReadRegister1  input  ADDR_BITS  read port 1 address.
- ReadRegister2  input  ADDR_BITS  read port 2 address.
- ReadData1  output  WIDTH  read port 1 data.
- ReadData2  output  WIDTH  read port 2 data.
- WriteRegister  input  ADDR_BITS  write address.
- WriteData  input  WIDTH  write data.
- RegWrite  input  1  write enable, active high.
- ClearReq  input  1  request to zero all registers; sampled on Clk.
- Busy  output  1  high while the clear sequence runs.
- ClearDone  output  1  one-cycle pulse when a clear sequence completes.

Function
REQ-003 Read ports SHALL be combinational and independent: ReadDataN = reg[ReadRegisterN].
REQ-004 Register 0 SHALL always read 0, and any write to address 0 SHALL be discarded.
REQ-005 In IDLE, a rising Clk with RegWrite=1 and WriteRegister≠0 SHALL store WriteData into reg[WriteRegister]; no other register SHALL change.
REQ-006 With RegWrite=0, no register SHALL change on any edge.
REQ-007 The FSM SHALL have states IDLE and CLEAR, and SHALL hold a clear index counter of ADDR_BITS width.
REQ-008 In IDLE with ClearReq=1 at a rising edge, the FSM SHALL enter CLEAR with index=1, and no user write SHALL occur on that edge.
REQ-009 In CLEAR, each rising edge SHALL write 0 to reg[index] and increment index.
REQ-010 When index = NUM_REGS-1, that edge SHALL return the FSM to IDLE.
REQ-011 A clear SHALL take exactly NUM_REGS-1 edges (31 at the defaults).
REQ-012 Busy SHALL equal (state==CLEAR).
REQ-013 ClearDone SHALL be registered, high for exactly the one cycle following the edge that leaves CLEAR, and low otherwise.
REQ-014 While Busy=1, RegWrite SHALL be ignored; the write is dropped, not queued.
REQ-015 ClearReq asserted while Busy=1 SHALL be ignored; it SHALL NOT restart or extend the sequence.
REQ-016 Reads during CLEAR SHALL return current contents: already-cleared registers read 0, uncleared registers keep their old values.
REQ-017 The index counter SHALL never wrap during a sequence, and SHALL never address reg 0 for a write.

Reset
REQ-018 Reset=1 SHALL asynchronously force state=CLEAR, index=1, Busy=1 and ClearDone=0.
REQ-019 The register array SHALL have no reset; it SHALL be zeroed by the post-reset clear sequence.
REQ-020 Reset asserted mid-clear SHALL restart the sequence from index 1 after deassertion.
REQ-021 ReadData during reset SHALL equal current array contents, except reg 0, which SHALL read 0.

Configuration
REQ-022 With macro REGFILE_BYPASS_EN defined, a read port whose address equals WriteRegister SHALL return WriteData combinationally, in the same cycle, when RegWrite=1, Busy=0 and WriteRegister≠0.
REQ-023 Without REGFILE_BYPASS_EN, read ports SHALL return the pre-edge stored value until the write edge occurs.

Structure
REQ-024 Package regfile_pkg SHALL hold the WIDTH and ADDR_BITS defaults, the NUM_REGS constant, and the FSM state encoding (IDLE, CLEAR).
REQ-025 The FSM, index counter, Busy and ClearDone logic SHALL reside in sub-module regfile_clear_fsm, which supplies the clear write address and enable to the top-level array and write mux.

Verification
REQ-026 Reset then release -> Busy=1 for 31 cycles, ClearDone pulses once, and every register reads 0 on both ports.
REQ-027 Write 42 to reg 2, then 15 to reg 2 -> ReadData1=ReadData2=15; a later write of 27 with RegWrite=0 -> still 15.
REQ-028 Write 19 to reg 0 -> both ports read 0; write index i to reg i for i=1..31 -> each reg reads i on both ports with different addresses on each port.
REQ-029 Write 38 to reg 17, pulse ClearReq, and attempt a write of 5 to reg 3 during Busy -> reg 17 and reg 3 read 0 after ClearDone.
REQ-030 Assert Reset at clear cycle 10, release, then wait -> Busy lasts a full 31 cycles after release with a single ClearDone pulse; ClearReq during Busy causes no extra pulse.
REQ-031 With REGFILE_BYPASS_EN defined, drive WriteRegister=ReadRegister1=9, WriteData=77, RegWrite=1 before the edge -> ReadData1=77; without the macro -> the old value until after the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and clear-FSM state encoding for regfile_autoclear
package regfile_pkg;
  localparam int WIDTH = 32;
  localparam int ADDR_BITS = 5;
  localparam int NUM_REGS = 2 ** ADDR_BITS;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequences zero-writes over regs 1..NUM_REGS-1, drives Busy and ClearDone
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_BITS = regfile_pkg::ADDR_BITS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ClearReq,
  output logic                 Busy,
  output logic                 ClearDone,
  output logic                 clr_we,
  output logic [ADDR_BITS-1:0] clr_addr
);
  state_t state, state_n;
  logic [ADDR_BITS-1:0] index, index_n;
  logic done, done_n, last;
  assign last = &index;
  // state, index and done pulse registers; reset starts a clear sequence
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= CLEAR;
      index <= ADDR_BITS'(1);
      done  <= 1'b0;
    end else begin
      state <= state_n;
      index <= index_n;
      done  <= done_n;
    end
  // next state: index parks at 1 outside CLEAR so it never wraps or reaches reg 0
  always_comb begin
    state_n = (state == IDLE) ? (ClearReq ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    index_n = (state == CLEAR && !last) ? index + 1'b1 : ADDR_BITS'(1);
    done_n  = (state == CLEAR) && last;
  end
  // outputs to the array write mux and the status pins
  always_comb begin
    Busy      = (state == CLEAR);
    clr_we    = (state == CLEAR);
    clr_addr  = index;
    ClearDone = done;
  end
endmodule

// File: rtl/regfile_autoclear.sv
// regfile_autoclear: 2R1W register file with hardware clear sequence; REGFILE_BYPASS_EN enables write-to-read bypass
module regfile_autoclear
  import regfile_pkg::*;
#(
  parameter int WIDTH     = regfile_pkg::WIDTH,
  parameter int ADDR_BITS = regfile_pkg::ADDR_BITS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [ADDR_BITS-1:0] ReadRegister1,
  input  logic [ADDR_BITS-1:0] ReadRegister2,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  input  logic [ADDR_BITS-1:0] WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic                 RegWrite,
  input  logic                 ClearReq,
  output logic                 Busy,
  output logic                 ClearDone
);
  localparam int NREGS = 2 ** ADDR_BITS;
  logic [WIDTH-1:0] regs [NREGS];
  logic clr_we, user_we;
  logic [ADDR_BITS-1:0] clr_addr;
  regfile_clear_fsm #(.ADDR_BITS(ADDR_BITS)) u_fsm (
    .Clk      (Clk),
    .Reset    (Reset),
    .ClearReq (ClearReq),
    .Busy     (Busy),
    .ClearDone(ClearDone),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
  assign user_we = RegWrite && !Busy && !ClearReq && (WriteRegister != '0);
  // array has no reset; the clear sequence owns the write port while busy
  always_ff @(posedge Clk)
    if (clr_we) regs[clr_addr] <= '0;
    else if (user_we) regs[WriteRegister] <= WriteData;
`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  assign byp_en = RegWrite && !Busy && (WriteRegister != '0);
  assign ReadData1 = (ReadRegister1 == '0) ? '0 :
                     (byp_en && ReadRegister1 == WriteRegister) ? WriteData : regs[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == '0) ? '0 :
                     (byp_en && ReadRegister2 == WriteRegister) ? WriteData : regs[ReadRegister2];
`else
  assign ReadData1 = (ReadRegister1 == '0) ? '0 : regs[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == '0) ? '0 : regs[ReadRegister2];
`endif
endmodule

// File: tb/tb_regfile_autoclear.sv
// tb_regfile_autoclear: directed stimulus with a queued-expectation scoreboard
module tb_regfile_autoclear;
  logic Clk = 1'b0, Reset = 1'b0;
  logic [4:0] ReadRegister1 = '0, ReadRegister2 = '0, WriteRegister = '0;
  logic [31:0] WriteData = '0;
  logic RegWrite = 1'b0, ClearReq = 1'b0;
  logic [31:0] ReadData1, ReadData2;
  logic Busy, ClearDone;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [3:0] RD = 4'b0011, ST = 4'b1100, ALL = 4'b1111;
  typedef struct {
    logic [3:0]  m;
    logic [31:0] e1, e2;
    logic        eb, ed;
    string       nm;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  regfile_autoclear dut (
    .Clk(Clk), .Reset(Reset),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RegWrite(RegWrite), .ClearReq(ClearReq),
    .Busy(Busy), .ClearDone(ClearDone)
  );
  always #5 Clk = ~Clk;
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask
  // monitor: pops one expectation per presented sample, mid-cycle
  always @(negedge Clk)
    if (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      if (it.m[0]) cmp({it.nm, ".rd1"}, ReadData1, it.e1);
      if (it.m[1]) cmp({it.nm, ".rd2"}, ReadData2, it.e2);
      if (it.m[2]) cmp({it.nm, ".busy"}, {31'b0, Busy}, {31'b0, it.eb});
      if (it.m[3]) cmp({it.nm, ".done"}, {31'b0, ClearDone}, {31'b0, it.ed});
    end
  task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic cr,
                      input logic [3:0] m, input logic [31:0] e1, input logic [31:0] e2,
                      input logic eb, input logic ed, input string nm);
    exp_t it;
    @(posedge Clk);
    #1;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
    RegWrite = we;
    WriteRegister = wa;
    WriteData = wd;
    ClearReq = cr;
    if (m != 4'b0) begin
      it.m = m; it.e1 = e1; it.e2 = e2; it.eb = eb; it.ed = ed; it.nm = nm;
      q.push_back(it);
    end
  endtask
  task automatic clear_run(input int from, input int creq_at, input string nm);
    for (int k = from; k <= 32; k++)
      step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, k == creq_at, ALL, 32'd0, 32'd0, k < 31, k == 31, nm);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #2 Reset = 1'b1;
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, ALL, 32'd0, 32'd0, 1'b1, 1'b0, "reset");
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, ALL, 32'd0, 32'd0, 1'b1, 1'b0, "reset");
    Reset = 1'b0;
    clear_run(1, -1, "post_reset");
    for (int a = 0; a < 32; a++)
      step(5'(a), 5'(31 - a), 1'b0, 5'd0, 32'd0, 1'b0, RD, 32'd0, 32'd0, 1'b0, 1'b0, "zeroed");
    step(5'd0, 5'd0, 1'b1, 5'd2, 32'd42, 1'b0, 4'b0, 32'd0, 32'd0, 1'b0, 1'b0, "");
    step(5'd2, 5'd2, 1'b1, 5'd2, 32'd15, 1'b0, RD, BYP ? 32'd15 : 32'd42, BYP ? 32'd15 : 32'd42, 1'b0, 1'b0, "pre_write");
    step(5'd2, 5'd2, 1'b0, 5'd2, 32'd27, 1'b0, RD, 32'd15, 32'd15, 1'b0, 1'b0, "overwrite");
    step(5'd2, 5'd2, 1'b0, 5'd2, 32'd27, 1'b0, RD, 32'd15, 32'd15, 1'b0, 1'b0, "no_we");
    step(5'd0, 5'd0, 1'b1, 5'd0, 32'd19, 1'b0, RD, 32'd0, 32'd0, 1'b0, 1'b0, "r0_write");
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, RD, 32'd0, 32'd0, 1'b0, 1'b0, "r0_after");
    for (int i = 1; i < 32; i++)
      step(5'd0, 5'd0, 1'b1, 5'(i), 32'(i), 1'b0, 4'b0, 32'd0, 32'd0, 1'b0, 1'b0, "");
    for (int i = 1; i < 32; i++)
      step(5'(i), 5'((i % 31) + 1), 1'b0, 5'd0, 32'd0, 1'b0, RD, 32'(i), 32'((i % 31) + 1), 1'b0, 1'b0, "fill");
    step(5'd9, 5'd8, 1'b1, 5'd9, 32'd77, 1'b0, RD, BYP ? 32'd77 : 32'd9, 32'd8, 1'b0, 1'b0, "bypass");
    step(5'd9, 5'd8, 1'b0, 5'd0, 32'd0, 1'b0, RD, 32'd77, 32'd8, 1'b0, 1'b0, "post_edge");
    step(5'd0, 5'd0, 1'b1, 5'd17, 32'd38, 1'b0, 4'b0, 32'd0, 32'd0, 1'b0, 1'b0, "");
    step(5'd17, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, RD | 4'b0100, 32'd38, 32'd3, 1'b0, 1'b0, "clr_req");
    for (int k = 0; k <= 32; k++)
      step(5'd3, 5'd17, k <= 5, 5'd3, 32'd5, k == 10, RD | ST,
           (k >= 3) ? 32'd0 : 32'd3, (k >= 17) ? 32'd0 : 32'd38, k < 31, k == 31, "clearing");
    step(5'd3, 5'd17, 1'b0, 5'd0, 32'd0, 1'b0, RD, 32'd0, 32'd0, 1'b0, 1'b0, "after_clear");
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, ST, 32'd0, 32'd0, 1'b0, 1'b0, "creq2");
    for (int k = 0; k < 10; k++)
      step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, ST, 32'd0, 32'd0, 1'b1, 1'b0, "pre_reset");
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, ST, 32'd0, 32'd0, 1'b1, 1'b0, "reset_hit");
    Reset = 1'b1;
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, ALL, 32'd0, 32'd0, 1'b1, 1'b0, "in_reset");
    Reset = 1'b0;
    clear_run(1, 12, "restart");
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, ST, 32'd0, 32'd0, 1'b0, 1'b0, "no_extra");
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, ST, 32'd0, 32'd0, 1'b0, 1'b0, "no_extra");
    @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
